// File: rtl/xadac_vrf_mp.sv
// xadac_vrf_mp: multi-port vector register file with registered reads, per-byte writes,
// destination busy scoreboard and post-reset zeroing sweep. Optional: XADAC_VRF_BYPASS_EN.
module xadac_vrf_mp #(
  parameter int VectorWidth   = 256,
  parameter int NumRegs       = 32,
  parameter int NumReadPorts  = 3,
  parameter int NumWritePorts = 2,
  parameter int IdW           = $clog2(NumRegs)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  output logic                                   ready,
  input  logic [NumReadPorts-1:0]                rvalid,
  input  logic [NumReadPorts*IdW-1:0]            rid,
  output logic [NumReadPorts*VectorWidth-1:0]    rdata,
  output logic [NumReadPorts-1:0]                rdata_valid,
  input  logic [NumWritePorts-1:0]               we,
  input  logic [NumWritePorts*IdW-1:0]           wid,
  input  logic [NumWritePorts*VectorWidth-1:0]   wdata,
  input  logic [NumWritePorts*(VectorWidth/8)-1:0] wbe,
  input  logic                                   rsv_valid,
  input  logic [IdW-1:0]                         rsv_id,
  output logic                                   rsv_ready,
  output logic [NumRegs-1:0]                     busy
);
  localparam int NumBytes = VectorWidth / 8;
  localparam logic [IdW-1:0] LastId = IdW'(NumRegs - 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t                                state_q, state_d;
  logic [IdW-1:0]                        cnt_q, cnt_d;
  logic                                  ready_q, ready_d;
  logic [NumRegs-1:0]                    busy_q, busy_d;
  logic [NumReadPorts*VectorWidth-1:0]   rdata_q, rdata_d;
  logic [NumReadPorts-1:0]               rdata_valid_q, rdata_valid_d;
  logic [VectorWidth-1:0]                mem_q [NumRegs];
  logic [VectorWidth-1:0]                mem_d [NumRegs];

  assign ready       = ready_q;
  assign busy        = busy_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign rsv_ready   = ready_q & rsv_valid & ~busy_q[rsv_id];

  // ready trails the INIT->RUN transition by one registered cycle
  always_comb begin : ctrl
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = (state_q == RUN);
    if (state_q == INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LastId) state_d = RUN;
    end
  end

  // Ascending port loop lets the highest-index port win per byte
  always_comb begin : storage
    mem_d = mem_q;
    if (state_q == INIT) begin
      mem_d[cnt_q] = '0;
    end else begin
      for (int p = 0; p < NumWritePorts; p++) begin
        if (we[p]) begin
          for (int b = 0; b < NumBytes; b++) begin
            if (wbe[p*NumBytes + b])
              mem_d[wid[p*IdW +: IdW]][b*8 +: 8] = wdata[p*VectorWidth + b*8 +: 8];
          end
        end
      end
    end
  end

  always_comb begin : read
    rdata_d       = rdata_q;
    rdata_valid_d = '0;
    for (int p = 0; p < NumReadPorts; p++) begin
      if (state_q == RUN && rvalid[p]) begin
        rdata_valid_d[p] = 1'b1;
`ifdef XADAC_VRF_BYPASS_EN
        rdata_d[p*VectorWidth +: VectorWidth] = mem_d[rid[p*IdW +: IdW]];
`else
        rdata_d[p*VectorWidth +: VectorWidth] = mem_q[rid[p*IdW +: IdW]];
`endif
      end
    end
  end

  // Clears first so a same-cycle reservation of the same register wins
  always_comb begin : scoreboard
    busy_d = busy_q;
    if (state_q == RUN) begin
      for (int p = 0; p < NumWritePorts; p++) begin
        if (we[p] && |wbe[p*NumBytes +: NumBytes]) busy_d[wid[p*IdW +: IdW]] = 1'b0;
      end
    end
    if (rsv_ready) busy_d[rsv_id] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= INIT;
      cnt_q         <= '0;
      ready_q       <= 1'b0;
      busy_q        <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ready_q       <= ready_d;
      busy_q        <= busy_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_xadac_vrf_mp.sv
// Self-checking bench for xadac_vrf_mp: directed scenarios plus randomized traffic
// compared each cycle against a byte-level behavioural model.
module tb_xadac_vrf_mp;
  localparam int VW  = 256;
  localparam int NR  = 32;
  localparam int NRP = 3;
  localparam int NWP = 2;
  localparam int IDW = 5;
  localparam int NB  = VW / 8;
`ifdef XADAC_VRF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 ready;
  logic [NRP-1:0]       rvalid;
  logic [NRP*IDW-1:0]   rid;
  logic [NRP*VW-1:0]    rdata;
  logic [NRP-1:0]       rdata_valid;
  logic [NWP-1:0]       we;
  logic [NWP*IDW-1:0]   wid;
  logic [NWP*VW-1:0]    wdata;
  logic [NWP*NB-1:0]    wbe;
  logic                 rsv_valid;
  logic [IDW-1:0]       rsv_id;
  logic                 rsv_ready;
  logic [NR-1:0]        busy;

  always #5 clk = ~clk;

  xadac_vrf_mp #(
    .VectorWidth(VW), .NumRegs(NR), .NumReadPorts(NRP), .NumWritePorts(NWP)
  ) dut (
    .clk(clk), .rst(rst), .ready(ready),
    .rvalid(rvalid), .rid(rid), .rdata(rdata), .rdata_valid(rdata_valid),
    .we(we), .wid(wid), .wdata(wdata), .wbe(wbe),
    .rsv_valid(rsv_valid), .rsv_id(rsv_id), .rsv_ready(rsv_ready), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Behavioural model: storage as bytes, edges counted since reset release
  logic [7:0]    m_mem [NR][NB];
  logic [7:0]    m_nxt [NR][NB];
  logic [VW-1:0] m_rdata [NRP];
  logic [NRP-1:0] m_rv = '0;
  logic [NR-1:0] m_busy = '0;
  logic          m_ready = 1'b0;
  int            m_k = 0;

  function automatic logic [VW-1:0] row(input int r, input bit post);
    logic [VW-1:0] v;
    for (int b = 0; b < NB; b++) v[b*8 +: 8] = post ? m_nxt[r][b] : m_mem[r][b];
    return v;
  endfunction

  task automatic model_edge(input bit acc);
    if (rst) begin
      m_k = 0; m_ready = 1'b0; m_busy = '0; m_rv = '0;
      for (int p = 0; p < NRP; p++) m_rdata[p] = '0;
      for (int r = 0; r < NR; r++) for (int b = 0; b < NB; b++) m_mem[r][b] = 8'h00;
      return;
    end
    m_k++;
    m_nxt = m_mem;
    if (m_k > NR) begin
      for (int p = 0; p < NWP; p++)
        if (we[p])
          for (int b = 0; b < NB; b++)
            if (wbe[p*NB + b]) m_nxt[int'(wid[p*IDW +: IDW])][b] = wdata[p*VW + b*8 +: 8];
    end
    m_rv = '0;
    for (int p = 0; p < NRP; p++) begin
      if (m_k > NR && rvalid[p]) begin
        m_rv[p] = 1'b1;
        m_rdata[p] = row(int'(rid[p*IDW +: IDW]), BYP);
      end
    end
    if (m_k > NR) begin
      for (int p = 0; p < NWP; p++)
        if (we[p] && (wbe[p*NB +: NB] != '0)) m_busy[wid[p*IDW +: IDW]] = 1'b0;
    end
    if (acc) m_busy[rsv_id] = 1'b1;
    m_mem = m_nxt;
    m_ready = (m_k >= NR + 1);
  endtask

  // One clock: check combinational grant, advance model, check registered outputs
  task automatic tick();
    bit acc;
    #1;
    acc = m_ready && rsv_valid && !m_busy[rsv_id];
    check_eq("rsv_ready", VW'(rsv_ready), VW'(acc));
    model_edge(acc);
    @(posedge clk);
    #1;
    check_eq("ready", VW'(ready), VW'(m_ready));
    check_eq("busy", VW'(busy), VW'(m_busy));
    check_eq("rdata_valid", VW'(rdata_valid), VW'(m_rv));
    for (int p = 0; p < NRP; p++) check_eq($sformatf("rdata%0d", p), rdata[p*VW +: VW], m_rdata[p]);
    @(negedge clk);
  endtask

  task automatic idle();
    rvalid = '0; rid = '0; we = '0; wid = '0; wdata = '0; wbe = '0;
    rsv_valid = 1'b0; rsv_id = '0;
  endtask

  task automatic wr(input int p, input int id, input logic [VW-1:0] d, input logic [NB-1:0] be);
    we[p] = 1'b1;
    wid[p*IDW +: IDW] = IDW'(id);
    wdata[p*VW +: VW] = d;
    wbe[p*NB +: NB] = be;
  endtask

  task automatic rd(input int p, input int id);
    rvalid[p] = 1'b1;
    rid[p*IDW +: IDW] = IDW'(id);
  endtask

  function automatic logic [VW-1:0] rnd_vec();
    logic [VW-1:0] v;
    for (int i = 0; i < VW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic read_all_zero(input string tag);
    for (int r = 0; r < NR; r += NRP) begin
      idle();
      for (int p = 0; p < NRP; p++) rd(p, (r + p) % NR);
      tick();
      for (int p = 0; p < NRP; p++) check_eq(tag, rdata[p*VW +: VW], '0);
    end
  endtask

  initial begin
    logic [NB-1:0] be;
    idle();
    rst = 1'b1;
    tick();
    tick();
    check_eq("rst_busy", VW'(busy), '0);
    check_eq("rst_ready", VW'(ready), '0);
    check_eq("rst_rdata", VW'(rdata), '0);
    rst = 1'b0;
    for (int k = 1; k <= NR + 1; k++) begin
      tick();
      check_eq($sformatf("sweep_ready_c%0d", k), VW'(ready), VW'(k >= NR + 1));
    end
    read_all_zero("sweep_zero");

    idle(); wr(0, 5, {32{8'hAA}}, 32'h0000_000F); tick();
    idle(); rd(0, 5); tick();
    check_eq("be_data", rdata[0 +: VW], {{28{8'h00}}, {4{8'hAA}}});
    check_eq("be_valid", VW'(rdata_valid), VW'(3'b001));
    idle(); tick();
    check_eq("be_valid_drop", VW'(rdata_valid), '0);

    idle(); wr(0, 3, {32{8'h11}}, '1); wr(1, 3, {32{8'h22}}, '1); tick();
    idle(); rd(1, 3); tick();
    check_eq("wr_conflict", rdata[VW +: VW], {32{8'h22}});

    idle(); wr(0, 7, {32{8'h55}}, '1); tick();
    idle(); wr(1, 7, {32{8'hCC}}, '1); rd(2, 7); tick();
    check_eq("same_cycle_rw", rdata[2*VW +: VW], BYP ? {32{8'hCC}} : {32{8'h55}});
    idle(); rd(2, 7); tick();
    check_eq("rw_next", rdata[2*VW +: VW], {32{8'hCC}});

    idle(); rsv_valid = 1'b1; rsv_id = 5'd9; #1;
    check_eq("rsv9_grant", VW'(rsv_ready), VW'(1'b1));
    tick();
    check_eq("rsv9_busy", VW'(busy[9]), VW'(1'b1));
    #1;
    check_eq("rsv9_refuse", VW'(rsv_ready), '0);
    tick();
    idle(); wr(0, 9, rnd_vec(), '1); tick();
    check_eq("wr9_clear", VW'(busy[9]), '0);
    idle(); rsv_valid = 1'b1; rsv_id = 5'd9; wr(1, 9, rnd_vec(), '1); tick();
    check_eq("set_wins", VW'(busy[9]), VW'(1'b1));
    idle(); wr(0, 9, rnd_vec(), 32'h0000_0100); tick();

    for (int i = 0; i < 1500; i++) begin
      idle();
      for (int p = 0; p < NRP; p++)
        if ($urandom % 2 == 0) rd(p, ($urandom % 2 == 0) ? int'($urandom % 8) : int'($urandom % NR));
      for (int p = 0; p < NWP; p++) begin
        if ($urandom % 3 == 0) begin
          be = $urandom;
          case ($urandom % 8)
            0: be = '0;
            1, 2: be = '1;
            default: ;
          endcase
          wr(p, int'($urandom % 8), rnd_vec(), be);
        end
      end
      if ($urandom % 3 == 0) begin
        rsv_valid = 1'b1;
        rsv_id = IDW'($urandom % 8);
      end
      tick();
    end

    for (int r = 0; r < NR; r += NWP) begin
      idle(); wr(0, r, rnd_vec(), '1); wr(1, r + 1, rnd_vec(), '1); tick();
    end
    idle(); rsv_valid = 1'b1; rsv_id = 5'd8; tick();
    idle(); rsv_valid = 1'b1; rsv_id = 5'd9; tick();
    check_eq("pre_rst_busy", VW'(busy), VW'(32'h0000_0300));
    idle(); rst = 1'b1; tick();
    check_eq("mid_rst_busy", VW'(busy), '0);
    check_eq("mid_rst_ready", VW'(ready), '0);
    rst = 1'b0;
    for (int k = 1; k <= NR; k++) begin
      idle();
      wr(0, int'($urandom % NR), rnd_vec(), '1);
      rd(0, int'($urandom % NR));
      rsv_valid = 1'b1;
      rsv_id = IDW'($urandom % NR);
      tick();
      check_eq("init_no_valid", VW'(rdata_valid), '0);
    end
    idle(); tick();
    check_eq("mid_rst_ready_back", VW'(ready), VW'(1'b1));
    read_all_zero("mid_rst_zero");
    check_eq("mid_rst_busy_end", VW'(busy), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/xadac_vrf_mp.md
# xadac_vrf_mp

Multi-port, parametrised vector register file for the xadac accelerator datapath, sitting between the instruction decode/issue stage and the vector execution units. Generalises the single-write, three-read combinational VRF with:
- configurable read/write port counts, register count and vector width;
- registered reads;
- per-byte write enables on every write port;
- a busy scoreboard for destination reservation;
- a post-reset zeroing sequencer.

## Interface

Parameters:
- VectorWidth, 256, vector register width in bits; multiple of 8
- NumRegs, 32, number of vector registers; power of two, ≥ 2
- NumReadPorts, 3, independent read ports
- NumWritePorts, 2, independent write ports
- IdW, $clog2(NumRegs), derived register-id width

Ports:
- clk  in  1  sole clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- ready  out  1  high once zeroing sequence is complete
- rvalid  in  NumReadPorts  per-port read request
- rid  in  NumReadPorts×IdW  per-port read register id
- rdata  out  NumReadPorts×VectorWidth  registered read data
- rdata_valid  out  NumReadPorts  rdata qualifier
- we  in  NumWritePorts  per-port write enable
- wid  in  NumWritePorts×IdW  write register id
- wdata  in  NumWritePorts×VectorWidth  write data
- wbe  in  NumWritePorts×(VectorWidth/8)  byte enables
- rsv_valid  in  1  destination reservation request
- rsv_id  in  IdW  register to reserve
- rsv_ready  out  1  reservation accepted this cycle (combinational)
- busy  out  NumRegs  scoreboard bitmap, registered

## Operation

- FSM has two states:
  - INIT: entered on rst. A counter starts at 0. Each cycle, vrf[cnt] is set to all-zero and cnt increments. After the write to NumRegs-1, the FSM moves to RUN; ready rises in the following cycle (registered).
  - RUN: normal operation.
- In INIT, we, rvalid and rsv_valid are ignored. rdata_valid and rsv_ready stay 0.
- Writes (RUN):
  - Byte i of vrf[wid[p]] takes wdata[p] byte i when we[p] and wbe[p][i] are both set.
  - Same register, same byte from two ports in one cycle: the highest port index wins.
- Reads (RUN): when rvalid[p] is set, rdata[p] and rdata_valid[p] are registered one cycle later. Otherwise rdata_valid[p] is 0 and rdata[p] holds its previous value.
- Scoreboard:
  - rsv_ready = ready & rsv_valid & ~busy[rsv_id].
  - An accepted reservation sets busy[rsv_id].
  - Any write with we[p] set and at least one wbe bit set clears busy[wid[p]].
  - If a set and a clear target the same bit in the same cycle, the set wins.
  - Reserving a register that is already busy is refused; the requester must retry.
- Reset in any state returns to INIT with cnt = 0 and busy = 0. Register contents are then re-zeroed by the sweep.

## Timing

- Reset values: ready 0, rdata all 0, rdata_valid 0, busy 0, rsv_ready 0.
- Zeroing takes NumRegs cycles after rst deasserts. ready is high at cycle NumRegs+1.
- Read latency is 1 cycle. Write-to-storage latency is 1 cycle.
- Same-cycle read and write to one register: behaviour is set by the Configuration macro.
- busy updates are visible on the output the cycle after the reserve or write.

## Configuration

- XADAC_VRF_BYPASS_EN defined:
  - A read captured in the same cycle as a write to the same register returns the post-write value, merged per byte.
  - Each byte follows the highest-index enabled write port, or the stored value if no port writes that byte.
- XADAC_VRF_BYPASS_EN undefined:
  - The same case returns the pre-write stored value (read-before-write).
  - The new data is visible to reads issued one cycle later.

## Test plan

- Reset sweep: assert rst for 2 cycles, NumRegs = 32. Required: ready = 0 through cycle 32 and 1 at cycle 33; every register then reads 0; busy = 0.
- Byte-enable write: port 0 writes reg 5 with data 0xAA.., wbe = 0x0F. Reading reg 5 next cycle returns 0xAA in bytes 0–3 and 0 in all other bytes, with rdata_valid asserted exactly one cycle after rvalid.
- Write-port conflict: ports 0 and 1 both write reg 3, all bytes enabled, with 0x11.. and 0x22.. respectively. Reg 3 reads back as 0x22...
- Same-cycle read/write on reg 7 (holding 0x55.., new write 0xCC..): with XADAC_VRF_BYPASS_EN, rdata = 0xCC..; without the macro, rdata = 0x55...
- Scoreboard:
  - Reserve reg 9: rsv_ready = 1, then busy[9] = 1.
  - Reserve reg 9 again: rsv_ready = 0.
  - Write reg 9: busy[9] = 0.
  - Reserve and write reg 9 in the same cycle: busy[9] = 1.
- Mid-operation reset: rst while busy = 0x0000_0300 and regs hold data. Required: busy = 0 and ready = 0 the next cycle, writes ignored during INIT, all registers read 0 after ready returns.
